instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Ports SHALL be, clock and reset first: CLK  in  1  system clock.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 ReadAddress  in  8  processor PC (fetch address).
REQ-004 DataSwitch  in  8  instruction byte to load.
REQ-005 LoadButton  in  1  raw push-button; each press writes one byte.
REQ-006 RunButton  in  1  raw push-button; each press toggles LOAD/RUN.
REQ-007 Instruction  out  8  fetched instruction to processor.
REQ-008 CPUReset  out  1  high while processor must be held in reset.
REQ-009 LoadCount  out  9  number of bytes loaded (0..256).
REQ-010 Full  out  1  high when LoadCount = 256.
REQ-011 Running  out  1  high in RUN state.
REQ-012 Checksum  out  8  modulo-256 sum of loaded bytes (see Configuration).

Function
REQ-013 LoadButton and RunButton SHALL each pass a 2-flop synchronizer and a rising-edge detector, yielding a one-cycle pulse per press.
REQ-014 Memory SHALL be 256 x 8, written synchronously, read combinationally (zero-cycle fetch latency).
REQ-015 FSM states SHALL be LOAD and RUN only.
REQ-016 In LOAD, a LoadButton pulse with Full low SHALL write DataSwitch to mem[LoadCount[7:0]] and increment LoadCount by 1 in the same cycle.
REQ-017 In LOAD, a LoadButton pulse with Full high SHALL be ignored: no write, LoadCount held at 256, no wrap to 0.
REQ-018 LOAD -> RUN SHALL occur on a RunButton pulse when LoadCount > 0; with LoadCount = 0 the pulse SHALL be ignored.
REQ-019 RUN -> LOAD SHALL occur on a RunButton pulse and SHALL clear LoadCount (and Checksum) to 0 in that cycle; memory contents need not be cleared.
REQ-020 LoadButton pulses in RUN SHALL be ignored.
REQ-021 Simultaneous LoadButton and RunButton pulses in LOAD SHALL execute the run transition only; the byte SHALL be discarded.
REQ-022 In RUN, Instruction SHALL equal mem[ReadAddress] when ReadAddress < LoadCount, else 8'h00.
REQ-023 In LOAD, Instruction SHALL be 8'h00.
REQ-024 CPUReset SHALL be high in LOAD and low in RUN, registered with the state, so the processor leaves reset in the first cycle of RUN with PC = 0.
REQ-025 Running SHALL equal (state == RUN); Full SHALL equal (LoadCount == 256).

Reset
REQ-026 Reset SHALL act asynchronously: state LOAD, LoadCount 0, Checksum 0, synchronizer and edge flops 0, CPUReset 1, Running 0, Full 0, Instruction 8'h00.
REQ-027 Reset asserted mid-load or mid-run SHALL abandon the operation; no partial write SHALL occur in the reset cycle.
REQ-028 Edge detectors SHALL NOT generate a pulse on reset release while a button is held down.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN: when defined, each accepted write SHALL add DataSwitch to Checksum modulo 256; when undefined, Checksum SHALL be constant 8'h00 and no accumulator register SHALL exist.

Structure
REQ-030 A shared package loader_pkg SHALL hold the state enumeration, MEM_DEPTH = 256, COUNT_W = 9, and NOP_INSTR = 8'h00.
REQ-031 Synchronizer plus rising-edge detector SHALL be one sub-module, button_edge, instantiated twice.

Verification
REQ-032 Reset, load 8'h41, 8'h82, 8'hC3, press Run -> LoadCount 3, Running 1, CPUReset 0; ReadAddress 1 -> 8'h82; ReadAddress 3 -> 8'h00; Checksum 8'h86 (with macro).
REQ-033 Press Run with LoadCount 0 -> state stays LOAD, CPUReset stays 1.
REQ-034 Load 256 bytes then a 257th (8'hFF) -> Full 1, LoadCount 256, mem[0] unchanged.
REQ-035 Load and Run pulses in same cycle after 2 loads -> Running 1, LoadCount 2, extra byte not written.
REQ-036 In RUN press Run -> LoadCount 0, Checksum 0, CPUReset 1, Instruction 8'h00; load 8'h10 -> mem[0] = 8'h10.
REQ-037 Assert Reset during a held LoadButton after 5 loads, release -> LoadCount 0, state LOAD, no write until button released and pressed again.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared types and constants for the instruction loader.
// Contents: state enumeration (LOAD/RUN), memory depth, byte-count width, NOP encoding.
package loader_pkg;
  typedef enum logic {LOAD, RUN} state_t;
  localparam int MEM_DEPTH = 256;
  localparam int COUNT_W = 9;
  localparam logic [7:0] NOP_INSTR = 8'h00;
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: switch/button inputs and processor-side outputs of the loader.
// master: drives ReadAddress, DataSwitch, LoadButton, RunButton; observes the rest.
// slave:  the loader itself; drives Instruction, CPUReset, LoadCount, Full, Running, Checksum.
interface instruction_loader_if;
  import loader_pkg::*;
  logic [7:0] ReadAddress;
  logic [7:0] DataSwitch;
  logic LoadButton;
  logic RunButton;
  logic [7:0] Instruction;
  logic CPUReset;
  logic [COUNT_W-1:0] LoadCount;
  logic Full;
  logic Running;
  logic [7:0] Checksum;
  modport master (
    output ReadAddress, DataSwitch, LoadButton, RunButton,
    input Instruction, CPUReset, LoadCount, Full, Running, Checksum
  );
  modport slave (
    input ReadAddress, DataSwitch, LoadButton, RunButton,
    output Instruction, CPUReset, LoadCount, Full, Running, Checksum
  );
endinterface

// File: rtl/instruction_loader_button_edge.sv
// button_edge: 2-flop synchronizer plus rising-edge detector, one pulse per press.
// Ports: clk, rst (async active-high), btn (raw button), pulse (one-cycle strobe).
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic s1, s2, prev;
  logic [2:0] vld;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      vld <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      prev <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  // Edges are suppressed until prev holds a real synchronized sample, so a
  // button held through reset release does not read as a fresh press.
  assign pulse = vld[2] & s2 & ~prev;
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: byte-at-a-time program loader feeding a processor fetch port.
// Ports: CLK, Reset (async active-high), bus (instruction_loader_if.slave).
// Optional LOADER_CHECKSUM_EN adds a modulo-256 checksum of accepted bytes.
module instruction_loader
  import loader_pkg::*;
(
  input logic CLK,
  input logic Reset,
  instruction_loader_if.slave bus
);
  logic load_p, run_p, full, we;
  state_t state, state_n;
  logic [COUNT_W-1:0] count, count_n;
  logic [7:0] mem [MEM_DEPTH];
  button_edge u_load (.clk(CLK), .rst(Reset), .btn(bus.LoadButton), .pulse(load_p));
  button_edge u_run (.clk(CLK), .rst(Reset), .btn(bus.RunButton), .pulse(run_p));
  assign full = count == COUNT_W'(MEM_DEPTH);
  // A run press wins over a simultaneous load press; the byte is dropped.
  always_comb begin
    state_n = state;
    count_n = count;
    we = 1'b0;
    if (state == RUN) begin
      if (run_p) begin
        state_n = LOAD;
        count_n = '0;
      end
    end else if (run_p) begin
      if (count != '0) state_n = RUN;
    end else if (load_p && !full) begin
      we = 1'b1;
      count_n = count + COUNT_W'(1);
    end
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state <= LOAD;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  always_ff @(posedge CLK)
    if (we) mem[count[7:0]] <= bus.DataSwitch;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) csum <= '0;
    else if (state == RUN && run_p) csum <= '0;
    else if (we) csum <= csum + bus.DataSwitch;
  assign bus.Checksum = csum;
`else
  assign bus.Checksum = NOP_INSTR;
`endif
  assign bus.Instruction = (state == RUN && {1'b0, bus.ReadAddress} < count) ? mem[bus.ReadAddress] : NOP_INSTR;
  assign bus.CPUReset = state == LOAD;
  assign bus.Running = state == RUN;
  assign bus.Full = full;
  assign bus.LoadCount = count;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and randomized checks of instruction_loader against a byte-array model.
module tb_instruction_loader;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_mem [256];
  int m_count = 0;
  bit m_run = 0;
  logic [7:0] m_csum = 8'h00;
  logic [7:0] first_byte;

  instruction_loader_if bus ();
  instruction_loader dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_i, exp_c;
    exp_i = (m_run && int'(bus.ReadAddress) < m_count) ? m_mem[bus.ReadAddress] : 8'h00;
`ifdef LOADER_CHECKSUM_EN
    exp_c = m_csum;
`else
    exp_c = 8'h00;
`endif
    check({tag, ".instr"}, 16'(bus.Instruction), 16'(exp_i));
    check({tag, ".cpureset"}, 16'(bus.CPUReset), 16'(!m_run));
    check({tag, ".running"}, 16'(bus.Running), 16'(m_run));
    check({tag, ".full"}, 16'(bus.Full), 16'(m_count == 256));
    check({tag, ".count"}, 16'(bus.LoadCount), 16'(m_count));
    check({tag, ".csum"}, 16'(bus.Checksum), 16'(exp_c));
  endtask

  // One press of either/both buttons, then the model applies the rules.
  task automatic press(input bit l, input bit r, input logic [7:0] d);
    @(negedge CLK);
    bus.DataSwitch = d;
    bus.LoadButton = l;
    bus.RunButton = r;
    repeat (5) @(negedge CLK);
    bus.LoadButton = 1'b0;
    bus.RunButton = 1'b0;
    repeat (5) @(negedge CLK);
    if (r) begin
      if (m_run) begin
        m_run = 0;
        m_count = 0;
        m_csum = 8'h00;
      end else if (m_count > 0) m_run = 1;
    end else if (l && !m_run && m_count < 256) begin
      m_mem[m_count] = d;
      m_count++;
      m_csum = m_csum + d;
    end
  endtask

  task automatic probe(input string tag, input logic [7:0] ra);
    bus.ReadAddress = ra;
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.ReadAddress = 8'h00;
    bus.DataSwitch = 8'h00;
    bus.LoadButton = 1'b0;
    bus.RunButton = 1'b0;
    repeat (3) @(negedge CLK);
    check_all("reset");
    Reset = 1'b0;
    repeat (5) @(negedge CLK);
    press(0, 1, 8'h00);
    probe("run_empty", 8'h00);
    press(1, 0, 8'h41);
    press(1, 0, 8'h82);
    press(1, 0, 8'hC3);
    probe("loading", 8'h01);
    press(0, 1, 8'h00);
    probe("run3_ra0", 8'h00);
    probe("run3_ra1", 8'h01);
    check("run3_ra1_lit", 16'(bus.Instruction), 16'h0082);
    probe("run3_ra3", 8'h03);
    press(0, 1, 8'h00);
    probe("back_load", 8'h00);
    press(1, 0, 8'h10);
    press(0, 1, 8'h00);
    probe("run_10", 8'h00);
    for (int k = 0; k < 3; k++) begin
      press(0, 1, 8'h00);
      for (int n = $urandom_range(1, 12); n > 0; n--) press(1, 0, 8'($urandom));
      press(0, 1, 8'h00);
      for (int j = 0; j < 6; j++) probe("rand_rd", 8'($urandom_range(0, 15)));
      press(1, 0, 8'h77);
      probe("run_load_ignored", 8'h00);
    end
    press(0, 1, 8'h00);
    press(1, 0, 8'h21);
    press(1, 0, 8'h22);
    press(1, 1, 8'hEE);
    probe("simul_ra1", 8'h01);
    probe("simul_ra2", 8'h02);
    press(0, 1, 8'h00);
    first_byte = 8'($urandom);
    press(1, 0, first_byte);
    for (int n = 1; n < 256; n++) press(1, 0, 8'($urandom));
    probe("full", 8'h00);
    press(1, 0, 8'hFF);
    probe("full_extra", 8'h00);
    press(0, 1, 8'h00);
    probe("full_ra0", 8'h00);
    check("full_ra0_lit", 16'(bus.Instruction), 16'(first_byte));
    probe("full_ra255", 8'hFF);
    for (int j = 0; j < 8; j++) probe("full_rand", 8'($urandom));
    press(0, 1, 8'h00);
    for (int n = 0; n < 5; n++) press(1, 0, 8'($urandom));
    @(negedge CLK);
    bus.DataSwitch = 8'h99;
    bus.LoadButton = 1'b1;
    repeat (6) @(negedge CLK);
    m_mem[m_count] = 8'h99;
    m_count++;
    m_csum = m_csum + 8'h99;
    #2 Reset = 1'b1;
    m_count = 0;
    m_run = 0;
    m_csum = 8'h00;
    #1;
    check_all("async_reset");
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (8) @(negedge CLK);
    probe("held_after_reset", 8'h00);
    bus.LoadButton = 1'b0;
    repeat (5) @(negedge CLK);
    probe("released", 8'h00);
    press(1, 0, 8'h5A);
    press(0, 1, 8'h00);
    probe("reload_ra0", 8'h00);
    check("reload_ra0_lit", 16'(bus.Instruction), 16'h005A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
